// File: rtl/spi_host_master.sv
// Host-side SPI master: valid/ready word commands in, MSB-first SPI words out.
// CPHA is fixed at 0; word width, SCLK divider, idle polarity and slave-select count are parameters.
module spi_host_master #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4,
    parameter int NUM_SS  = 2,
    parameter int CPOL    = 0,
    localparam int SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [SEL_W-1:0]  cmd_ss_sel,
    input  logic              cmd_last,
    input  logic              abort,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              SCLK,
    output logic              MOSI,
    output logic [NUM_SS-1:0] SS,
    input  logic              MISO
);

    // state     | meaning
    // IDLE      | no transaction, SS high, ready for the first word of a burst
    // SETUP     | SS low, SCLK idle for one divider period before the word
    // XFER      | 2*DATA_W SCLK edges, then a one-cycle response pulse
    // WAIT_NEXT | burst open, SS held low, waiting for the next word
    // GAP       | SS high for one divider period before returning to IDLE
    typedef enum logic [2:0] {IDLE, SETUP, XFER, WAIT_NEXT, GAP} state_t;

    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [DIV_W-1:0]  DIV_TC     = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_DONE  = EDGE_W'(2 * DATA_W);
    localparam logic [EDGE_W-1:0] EDGE_FINAL = EDGE_W'(2 * DATA_W - 1);
    localparam logic              SCLK_IDLE  = (CPOL != 0);

    state_t              state;
    logic [DIV_W-1:0]    div_cnt;
    logic [EDGE_W-1:0]   edge_cnt;
    logic [DATA_W-1:0]   tx_shift;
    logic [DATA_W-1:0]   rx_shift;
    logic                last_q;
    logic [NUM_SS-1:0]   ss_new;
    logic                abort_now;
    logic                div_tc;

    assign cmd_ready = (state == IDLE) || (state == WAIT_NEXT);
    assign busy      = (state != IDLE);
    assign div_tc    = (div_cnt == DIV_TC);
    assign abort_now = abort && ((state == SETUP) || (state == XFER) || (state == WAIT_NEXT));

    // Out-of-range selects leave every line deasserted; the word still runs.
    always_comb begin
        ss_new = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (int'(cmd_ss_sel) == i) begin
                ss_new[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            edge_cnt  <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            last_q    <= 1'b0;
            SCLK      <= SCLK_IDLE;
            MOSI      <= 1'b0;
            SS        <= '1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (abort_now) begin
                state   <= GAP;
                div_cnt <= '0;
                SCLK    <= SCLK_IDLE;
                SS      <= '1;
                MOSI    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd_valid) begin
                            tx_shift <= cmd_data;
                            MOSI     <= cmd_data[DATA_W-1];
                            last_q   <= cmd_last;
                            SS       <= ss_new;
                            div_cnt  <= '0;
                            edge_cnt <= '0;
                            state    <= SETUP;
                        end
                    end
                    SETUP: begin
                        if (div_tc) begin
                            div_cnt <= '0;
                            state   <= XFER;
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end
                    end
                    XFER: begin
                        if (edge_cnt == EDGE_DONE) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= rx_shift;
                            div_cnt   <= '0;
                            if (last_q) begin
                                state <= GAP;
                                SS    <= '1;
                                MOSI  <= 1'b0;
                            end else begin
                                state <= WAIT_NEXT;
                            end
                        end else if (div_tc) begin
                            div_cnt  <= '0;
                            SCLK     <= ~SCLK;
                            edge_cnt <= edge_cnt + EDGE_W'(1);
                            // Even count before the toggle means this is a leading edge.
                            if (!edge_cnt[0]) begin
                                rx_shift <= {rx_shift[DATA_W-2:0], MISO};
                            end else if (edge_cnt != EDGE_FINAL) begin
                                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                                MOSI     <= tx_shift[DATA_W-2];
                            end
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end
                    end
                    WAIT_NEXT: begin
                        if (cmd_valid) begin
                            tx_shift <= cmd_data;
                            MOSI     <= cmd_data[DATA_W-1];
                            last_q   <= cmd_last;
                            div_cnt  <= '0;
                            edge_cnt <= '0;
                            state    <= SETUP;
                        end
                    end
                    GAP: begin
                        if (div_tc) begin
                            div_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
